// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer
//   16x-oversampled 8N1 receive front end for the UART1 RXD pin. The async
//   line is synchronised, start edges are detected, and each bit is voted from
//   the synced samples at indices 7/8/9. Each byte is handed over through a
//   one-entry valid/ready holding register. Framing and overrun flags are sticky.
//
//   HCLK      in   system clock, rising edge
//   HRESET    in   synchronous active-high reset
//   EN        in   receiver enable (low forces IDLE, holding register kept)
//   BAUDDIV   in   HCLK cycles per sample tick (0 behaves as EN=0)
//   RXD       in   asynchronous serial input, idle high
//   RX_DATA   out  received byte
//   RX_VALID  out  RX_DATA holds an unread byte
//   RX_READY  in   consumer accepts on RX_VALID & RX_READY
//   FERR      out  sticky framing error
//   OVERRUN   out  sticky overrun
//   ERR_CLR   in   pulse clearing FERR and OVERRUN (a same-cycle set wins)
//   BUSY      out  FSM not in IDLE
module uart_rx_deframer #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_W      = 16
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             EN,
    input  logic [DIV_W-1:0] BAUDDIV,
    input  logic             RXD,
    output logic [7:0]       RX_DATA,
    output logic             RX_VALID,
    input  logic             RX_READY,
    output logic             FERR,
    output logic             OVERRUN,
    input  logic             ERR_CLR,
    output logic             BUSY
);

    localparam int unsigned SAMP_W = $clog2(OVERSAMPLE);
    localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(OVERSAMPLE - 1);
    localparam logic [SAMP_W-1:0] SAMP_LO   = SAMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SAMP_W-1:0] SAMP_MID  = SAMP_W'(OVERSAMPLE / 2);
    localparam logic [SAMP_W-1:0] SAMP_HI   = SAMP_W'(OVERSAMPLE / 2 + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic              r_sync1, r_sync2, r_prev;
    logic [DIV_W-1:0]  r_div_cnt;
    logic [SAMP_W-1:0] r_samp;
    logic              r_s_lo, r_s_mid, r_s_hi;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic [7:0]        r_data;
    logic              r_valid, r_ferr, r_ovr;

    logic w_en, w_fall, w_tick, w_bit_end, w_stop_eval;
    logic w_vote, w_stop_vote, w_xfer;
    logic w_start, w_shift_en, w_deliver, w_ferr_set, w_busy;

    assign w_en        = EN && (BAUDDIV != '0);
    assign w_fall      = r_prev & ~r_sync2;
    // >= rather than == so a BAUDDIV shrink mid-frame cannot run the divider past wrap
    assign w_tick      = (r_state != S_IDLE) && (r_div_cnt >= BAUDDIV - DIV_W'(1));
    assign w_bit_end   = w_tick && (r_samp == SAMP_LAST);
    assign w_stop_eval = w_tick && (r_samp == SAMP_HI);
    assign w_vote      = (r_s_lo & r_s_mid) | (r_s_lo & r_s_hi) | (r_s_mid & r_s_hi);
    // The stop bit is judged on the tick that takes its last sample, so that
    // sample is used live instead of from r_s_hi.
    assign w_stop_vote = (r_s_lo & r_s_mid) | (r_s_lo & r_sync2) | (r_s_mid & r_sync2);
    assign w_xfer      = r_valid & RX_READY;

    // Two-flop synchroniser plus previous-value copy for edge detection
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= RXD;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (!w_en) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_fall) w_next = S_START;
                S_START: if (w_bit_end) w_next = w_vote ? S_IDLE : S_DATA;
                S_DATA:  if (w_bit_end && (r_bit_idx == 3'd7)) w_next = S_STOP;
                S_STOP:  if (w_stop_eval) w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_busy     = (r_state != S_IDLE);
        w_start    = 1'b0;
        w_shift_en = 1'b0;
        w_deliver  = 1'b0;
        w_ferr_set = 1'b0;
        case (r_state)
            S_IDLE: w_start    = w_en && w_fall;
            S_DATA: w_shift_en = w_en && w_bit_end;
            S_STOP: begin
                if (w_en && w_stop_eval) begin
                    w_deliver  = w_stop_vote;
                    w_ferr_set = ~w_stop_vote;
                end
            end
            default: ;
        endcase
    end

    // Divider and sample counter; held at zero whenever the FSM is (or is
    // about to be) idle, and restarted on the start edge.
    always_ff @(posedge HCLK) begin
        if (HRESET || w_start || (w_next == S_IDLE)) begin
            r_div_cnt <= '0;
            r_samp    <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
            r_samp    <= (r_samp == SAMP_LAST) ? '0 : r_samp + SAMP_W'(1);
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_s_lo  <= 1'b1;
            r_s_mid <= 1'b1;
            r_s_hi  <= 1'b1;
        end else if (w_tick) begin
            if (r_samp == SAMP_LO)  r_s_lo  <= r_sync2;
            if (r_samp == SAMP_MID) r_s_mid <= r_sync2;
            if (r_samp == SAMP_HI)  r_s_hi  <= r_sync2;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else if (w_start) begin
            r_bit_idx <= '0;
        end else if (w_shift_en) begin
            r_shift[r_bit_idx] <= w_vote;
            r_bit_idx          <= r_bit_idx + 3'd1;
        end
    end

    // Holding register: a delivery coinciding with a transfer replaces the
    // byte; a delivery into an unread, untaken byte is dropped as an overrun.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_deliver && (!r_valid || w_xfer)) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end

            if (w_ferr_set)   r_ferr <= 1'b1;
            else if (ERR_CLR) r_ferr <= 1'b0;

            if (w_deliver && r_valid && !w_xfer) r_ovr <= 1'b1;
            else if (ERR_CLR)                    r_ovr <= 1'b0;
        end
    end

    assign RX_DATA  = r_data;
    assign RX_VALID = r_valid;
    assign FERR     = r_ferr;
    assign OVERRUN  = r_ovr;
    assign BUSY     = w_busy;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Testbench for uart_rx_deframer: drives 8N1 frames onto RXD and checks the
// holding register, flags and BUSY against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx_deframer;

    localparam int unsigned DIV_W = 16;

    logic             HCLK = 1'b0;
    logic             HRESET, EN, RXD, RX_READY, ERR_CLR;
    logic [DIV_W-1:0] BAUDDIV;
    logic [7:0]       RX_DATA;
    logic             RX_VALID, FERR, OVERRUN, BUSY;

    int checks = 0;
    int errors = 0;

    // Frame-level model of what the consumer should see
    logic       m_valid, m_ferr, m_ovr;
    logic [7:0] m_data;

    always #10 HCLK = ~HCLK;

    uart_rx_deframer #(.OVERSAMPLE(16), .DIV_W(DIV_W)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .EN(EN), .BAUDDIV(BAUDDIV), .RXD(RXD),
        .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
        .FERR(FERR), .OVERRUN(OVERRUN), .ERR_CLR(ERR_CLR), .BUSY(BUSY)
    );

    function automatic void model_reset();
        m_valid = 1'b0; m_data = 8'h00; m_ferr = 1'b0; m_ovr = 1'b0;
    endfunction

    // A completed frame: bad stop flags FERR; good stop loads the byte if the
    // register is free or being read that cycle, otherwise it is an overrun.
    function automatic void model_frame(input logic [7:0] d, input logic stop, input logic taken);
        if (!stop) m_ferr = 1'b1;
        else if (!m_valid || taken) begin m_data = d; m_valid = 1'b1; end
        else m_ovr = 1'b1;
    endfunction

    // Called on a negedge; leaves on a negedge.
    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input int unsigned bc, input int unsigned idle_bits);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            RXD = f[i];
            repeat (bc) @(negedge HCLK);
        end
        RXD = 1'b1;
        repeat (idle_bits * bc) @(negedge HCLK);
    endtask

    task automatic test_reset();
        HRESET = 1'b1; EN = 1'b0; RXD = 1'b1; RX_READY = 1'b0; ERR_CLR = 1'b0;
        BAUDDIV = DIV_W'(4);
        repeat (3) @(negedge HCLK);
        model_reset();
        checks++;
        if ({RX_VALID, RX_DATA, FERR, OVERRUN, BUSY} !== {m_valid, m_data, m_ferr, m_ovr, 1'b0}) begin
            errors++;
            $display("FAIL reset: got valid=%b data=%h ferr=%b ovr=%b busy=%b, expected 0 00 0 0 0",
                     RX_VALID, RX_DATA, FERR, OVERRUN, BUSY);
        end
        HRESET = 1'b0; EN = 1'b1;
        repeat (5) @(negedge HCLK);
        checks++;
        if (BUSY !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy: got %b expected 0", BUSY);
        end
    endtask

    task automatic test_nominal();
        int unsigned lat;
        logic        seen;
        logic [7:0]  d;
        int unsigned bd;
        BAUDDIV = DIV_W'(4); RX_READY = 1'b0; lat = 0; seen = 1'b0;
        fork
            send_frame(8'h93, 1'b1, 64, 1);
            begin
                for (int i = 0; i < 700 && !seen; i++) begin
                    @(negedge HCLK);
                    lat++;
                    if (RX_VALID === 1'b1) seen = 1'b1;
                end
            end
        join
        checks++;
        if (!seen || lat < 618 || lat > 620) begin
            errors++;
            $display("FAIL latency: got %0d cycles (seen=%b), expected 619+-1", lat, seen);
        end
        model_frame(8'h93, 1'b1, 1'b0);
        checks++;
        if ({RX_VALID, RX_DATA, FERR, OVERRUN} !== {m_valid, m_data, m_ferr, m_ovr}) begin
            errors++;
            $display("FAIL nominal_0x93: got %b %h %b %b expected %b %h %b %b",
                     RX_VALID, RX_DATA, FERR, OVERRUN, m_valid, m_data, m_ferr, m_ovr);
        end
        RX_READY = 1'b1; @(negedge HCLK); RX_READY = 1'b0; m_valid = 1'b0;
        checks++;
        if (RX_VALID !== m_valid) begin
            errors++;
            $display("FAIL nominal_take: got valid=%b expected %b", RX_VALID, m_valid);
        end
        for (int k = 0; k < 3; k++) begin
            d = 8'($urandom);
            bd = $urandom_range(1, 4);
            BAUDDIV = DIV_W'(bd);
            send_frame(d, 1'b1, 16 * bd, 1);
            model_frame(d, 1'b1, 1'b0);
            checks++;
            if ({RX_VALID, RX_DATA, FERR, OVERRUN} !== {m_valid, m_data, m_ferr, m_ovr}) begin
                errors++;
                $display("FAIL nominal_rand div=%0d: got %b %h %b %b expected %b %h %b %b", bd,
                         RX_VALID, RX_DATA, FERR, OVERRUN, m_valid, m_data, m_ferr, m_ovr);
            end
            RX_READY = 1'b1; @(negedge HCLK); RX_READY = 1'b0; m_valid = 1'b0;
        end
    endtask

    task automatic test_glitch();
        logic seen;
        BAUDDIV = DIV_W'(4); seen = 1'b0;
        RXD = 1'b0;
        for (int i = 0; i < 120; i++) begin
            if (i == 12) RXD = 1'b1;
            @(negedge HCLK);
            if (BUSY === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b1 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL glitch_busy: got pulse=%b busy_now=%b expected 1 0", seen, BUSY);
        end
        checks++;
        if ({RX_VALID, RX_DATA, FERR, OVERRUN} !== {m_valid, m_data, m_ferr, m_ovr}) begin
            errors++;
            $display("FAIL glitch_outputs: got %b %h %b %b expected %b %h %b %b",
                     RX_VALID, RX_DATA, FERR, OVERRUN, m_valid, m_data, m_ferr, m_ovr);
        end
    endtask

    task automatic test_framing_error();
        BAUDDIV = DIV_W'(4);
        send_frame(8'h5A, 1'b0, 64, 1);
        model_frame(8'h5A, 1'b0, 1'b0);
        checks++;
        if ({RX_VALID, RX_DATA, FERR, OVERRUN} !== {m_valid, m_data, m_ferr, m_ovr}) begin
            errors++;
            $display("FAIL ferr_set: got %b %h %b %b expected %b %h %b %b",
                     RX_VALID, RX_DATA, FERR, OVERRUN, m_valid, m_data, m_ferr, m_ovr);
        end
        ERR_CLR = 1'b1; @(negedge HCLK); ERR_CLR = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
        checks++;
        if (FERR !== m_ferr) begin
            errors++;
            $display("FAIL ferr_clear: got %b expected %b", FERR, m_ferr);
        end
        send_frame(8'h3C, 1'b1, 64, 1);
        model_frame(8'h3C, 1'b1, 1'b0);
        checks++;
        if ({RX_VALID, RX_DATA, FERR, OVERRUN} !== {m_valid, m_data, m_ferr, m_ovr}) begin
            errors++;
            $display("FAIL ferr_recover: got %b %h %b %b expected %b %h %b %b",
                     RX_VALID, RX_DATA, FERR, OVERRUN, m_valid, m_data, m_ferr, m_ovr);
        end
        RX_READY = 1'b1; @(negedge HCLK); RX_READY = 1'b0; m_valid = 1'b0;
    endtask

    task automatic test_overrun();
        BAUDDIV = DIV_W'(4); RX_READY = 1'b0;
        send_frame(8'h11, 1'b1, 64, 0);
        send_frame(8'h22, 1'b1, 64, 1);
        model_frame(8'h11, 1'b1, 1'b0);
        model_frame(8'h22, 1'b1, 1'b0);
        checks++;
        if ({RX_VALID, RX_DATA, FERR, OVERRUN} !== {m_valid, m_data, m_ferr, m_ovr}) begin
            errors++;
            $display("FAIL overrun_set: got %b %h %b %b expected %b %h %b %b",
                     RX_VALID, RX_DATA, FERR, OVERRUN, m_valid, m_data, m_ferr, m_ovr);
        end
        RX_READY = 1'b1; @(negedge HCLK); RX_READY = 1'b0; m_valid = 1'b0;
        ERR_CLR = 1'b1; @(negedge HCLK); ERR_CLR = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
        checks++;
        if ({RX_VALID, OVERRUN} !== {m_valid, m_ovr}) begin
            errors++;
            $display("FAIL overrun_clear: got valid=%b ovr=%b expected %b %b",
                     RX_VALID, OVERRUN, m_valid, m_ovr);
        end
        // Second byte loads 619 cycles after its start edge, which follows the
        // first start by 640 cycles; READY is raised for exactly that cycle.
        fork
            begin
                send_frame(8'h11, 1'b1, 64, 0);
                send_frame(8'h22, 1'b1, 64, 1);
            end
            begin
                repeat (640 + 618) @(negedge HCLK);
                RX_READY = 1'b1;
                @(negedge HCLK);
                RX_READY = 1'b0;
            end
        join
        model_frame(8'h11, 1'b1, 1'b0);
        model_frame(8'h22, 1'b1, 1'b1);
        checks++;
        if ({RX_VALID, RX_DATA, FERR, OVERRUN} !== {m_valid, m_data, m_ferr, m_ovr}) begin
            errors++;
            $display("FAIL overrun_simul_xfer: got %b %h %b %b expected %b %h %b %b",
                     RX_VALID, RX_DATA, FERR, OVERRUN, m_valid, m_data, m_ferr, m_ovr);
        end
        RX_READY = 1'b1; @(negedge HCLK); RX_READY = 1'b0; m_valid = 1'b0;
    endtask

    task automatic test_enable_midframe();
        BAUDDIV = DIV_W'(4);
        fork
            send_frame(8'h93, 1'b1, 64, 1);
            begin
                repeat (64 + 4 * 64 + 32) @(negedge HCLK);
                checks++;
                if (BUSY !== 1'b1) begin
                    errors++;
                    $display("FAIL en_busy_before: got %b expected 1", BUSY);
                end
                EN = 1'b0;
                @(negedge HCLK);
                checks++;
                if (BUSY !== 1'b0) begin
                    errors++;
                    $display("FAIL en_drop_idle: got busy=%b expected 0", BUSY);
                end
            end
        join
        checks++;
        if ({RX_VALID, FERR, OVERRUN, BUSY} !== {m_valid, m_ferr, m_ovr, 1'b0}) begin
            errors++;
            $display("FAIL en_drop_silent: got %b %b %b %b expected %b %b %b 0",
                     RX_VALID, FERR, OVERRUN, BUSY, m_valid, m_ferr, m_ovr);
        end
        EN = 1'b1;
        @(negedge HCLK);
        send_frame(8'hA5, 1'b1, 64, 1);
        model_frame(8'hA5, 1'b1, 1'b0);
        checks++;
        if ({RX_VALID, RX_DATA, FERR, OVERRUN} !== {m_valid, m_data, m_ferr, m_ovr}) begin
            errors++;
            $display("FAIL en_reenable: got %b %h %b %b expected %b %h %b %b",
                     RX_VALID, RX_DATA, FERR, OVERRUN, m_valid, m_data, m_ferr, m_ovr);
        end
        RX_READY = 1'b1; @(negedge HCLK); RX_READY = 1'b0; m_valid = 1'b0;
    endtask

    task automatic test_hreset_midframe();
        logic [7:0] d;
        BAUDDIV = DIV_W'(2);
        send_frame(8'hC3, 1'b0, 32, 1);
        send_frame(8'h77, 1'b1, 32, 1);
        model_frame(8'hC3, 1'b0, 1'b0);
        model_frame(8'h77, 1'b1, 1'b0);
        checks++;
        if ({RX_VALID, RX_DATA, FERR} !== {m_valid, m_data, m_ferr}) begin
            errors++;
            $display("FAIL hrst_setup: got %b %h %b expected %b %h %b",
                     RX_VALID, RX_DATA, FERR, m_valid, m_data, m_ferr);
        end
        fork
            send_frame(8'($urandom), 1'b1, 32, 1);
            begin
                repeat (150) @(negedge HCLK);
                HRESET = 1'b1;
                @(negedge HCLK);
                model_reset();
                checks++;
                if ({RX_VALID, RX_DATA, FERR, OVERRUN, BUSY} !== {m_valid, m_data, m_ferr, m_ovr, 1'b0}) begin
                    errors++;
                    $display("FAIL hrst_midframe: got %b %h %b %b %b expected 0 00 0 0 0",
                             RX_VALID, RX_DATA, FERR, OVERRUN, BUSY);
                end
            end
        join
        HRESET = 1'b0;
        @(negedge HCLK);
        d = 8'($urandom);
        send_frame(d, 1'b1, 32, 1);
        model_frame(d, 1'b1, 1'b0);
        checks++;
        if ({RX_VALID, RX_DATA, FERR, OVERRUN} !== {m_valid, m_data, m_ferr, m_ovr}) begin
            errors++;
            $display("FAIL hrst_recover: got %b %h %b %b expected %b %h %b %b",
                     RX_VALID, RX_DATA, FERR, OVERRUN, m_valid, m_data, m_ferr, m_ovr);
        end
        RX_READY = 1'b1; @(negedge HCLK); RX_READY = 1'b0; m_valid = 1'b0;
    endtask

    // Continuous-ready stream; every transfer seen at a negedge is collected
    // and compared, in order, against the bytes of the good-stop frames.
    task automatic test_stream(input int unsigned bd, input int unsigned nframes,
                               input logic fixed, input string name);
        logic [7:0]  dat[$];
        logic        stp[$];
        int unsigned gap[$];
        logic [7:0]  expq[$];
        logic [7:0]  got[$];
        int unsigned total;
        BAUDDIV = DIV_W'(bd); RX_READY = 1'b1; total = 0;
        for (int unsigned k = 0; k < nframes; k++) begin
            if (fixed) begin
                dat.push_back((k == 0) ? 8'h00 : 8'hFF);
                stp.push_back(1'b1);
                gap.push_back(1);
            end else begin
                dat.push_back(8'($urandom));
                stp.push_back($urandom_range(0, 4) != 0);
                gap.push_back($urandom_range(1, 2));
            end
            total += (10 + gap[k]) * 16 * bd;
            if (stp[k]) expq.push_back(dat[k]);
            else        m_ferr = 1'b1;
        end
        fork
            for (int unsigned k = 0; k < nframes; k++) send_frame(dat[k], stp[k], 16 * bd, gap[k]);
            for (int unsigned c = 0; c < total + 40; c++) begin
                @(negedge HCLK);
                if (RX_VALID === 1'b1 && RX_READY === 1'b1) got.push_back(RX_DATA);
            end
        join
        RX_READY = 1'b0;
        if (expq.size() > 0) m_data = expq[expq.size() - 1];
        checks++;
        if (got.size() != expq.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d bytes expected %0d", name, got.size(), expq.size());
        end
        for (int i = 0; i < got.size() && i < expq.size(); i++) begin
            checks++;
            if (got[i] !== expq[i]) begin
                errors++;
                $display("FAIL %s_byte%0d: got %h expected %h", name, i, got[i], expq[i]);
            end
        end
        checks++;
        if ({RX_VALID, FERR, OVERRUN} !== {m_valid, m_ferr, m_ovr}) begin
            errors++;
            $display("FAIL %s_flags: got valid=%b ferr=%b ovr=%b expected %b %b %b",
                     name, RX_VALID, FERR, OVERRUN, m_valid, m_ferr, m_ovr);
        end
        ERR_CLR = 1'b1; @(negedge HCLK); ERR_CLR = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic test_baud_scaling();
        test_stream(1, 2, 1'b1, "baud1");
    endtask

    task automatic test_random_stream();
        test_stream($urandom_range(1, 3), 12, 1'b0, "rand");
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_glitch();
        test_framing_error();
        test_overrun();
        test_enable_midframe();
        test_hreset_midframe();
        test_baud_scaling();
        test_random_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Serial-receive front end for the UART1 receive pin (RXD1) of SYSTEM_TOP.
- Synchronises the asynchronous line and oversamples it at 16x.
- Validates start/stop bits and assembles 8N1 frames, LSB first.
- Presents each byte through a one-entry valid/ready holding register to the APB UART register block, with sticky framing and overrun flags.

Parameters:
- OVERSAMPLE, 16, sample ticks per bit; sampling points below assume 16.
- DIV_W, 16, width of the BAUDDIV input.

Ports:
- HCLK  in  1  system clock; all logic on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- EN  in  1  receiver enable; low forces IDLE.
- BAUDDIV  in  DIV_W  HCLK cycles per sample tick; bit period = 16*BAUDDIV cycles.
- RXD  in  1  asynchronous serial input; idle high.
- RX_DATA  out  8  received byte.
- RX_VALID  out  1  RX_DATA holds an unread byte.
- RX_READY  in  1  consumer accepts byte when RX_VALID & RX_READY.
- FERR  out  1  sticky framing error.
- OVERRUN  out  1  sticky overrun.
- ERR_CLR  in  1  one-cycle pulse; clears FERR and OVERRUN.
- BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset (HRESET=1 at a clock edge): state IDLE; RX_DATA=0x00; RX_VALID=0; FERR=0; OVERRUN=0; BUSY=0; synchroniser flops=1; all counters=0. Reset mid-frame aborts the frame with no flag set.
- Synchroniser: 2 flops plus a registered copy for edge detection. Start detection latency is 3 HCLK cycles from the RXD pin.
- Tick generator:
  - Counts 0..BAUDDIV-1 and pulses tick on the terminal count.
  - Restarts at 0 on start-edge detection.
  - BAUDDIV=0 treated as EN=0.
- Sample counter: 4-bit, counts 0..15 per bit on ticks.
- Bit value: majority of synced samples at sample indices 7, 8, 9.
- FSM:
  - IDLE: on synced falling edge (prev=1, now=0) with EN=1 -> START; clear tick and sample counters.
  - START: at tick with sample=15, majority 0 -> DATA with bit index 0; majority 1 -> IDLE (glitch rejected, no flag).
  - DATA: at tick with sample=15, shift voted bit into bit[index] (LSB first). Index 7 -> STOP; otherwise index+1.
  - STOP: at tick with sample=9, evaluate the vote, then -> IDLE. The next start edge can be accepted from the following cycle, supporting back-to-back frames with a 0.5-bit tolerance.
    - Vote=1: deliver the byte.
    - Vote=0: FERR<=1, byte discarded.
- Delivery and handshake:
  - RX_VALID rises the cycle after the stop evaluation tick.
  - RX_DATA is stable while RX_VALID=1.
  - Transfer occurs on a cycle with RX_VALID & RX_READY; RX_VALID falls the next cycle unless a new byte loads in the same cycle.
  - Simultaneous transfer and new delivery: load the new byte, RX_VALID stays 1, no overrun.
  - Delivery while RX_VALID=1 and no transfer that cycle: OVERRUN<=1, new byte dropped, old byte retained.
- Flags: ERR_CLR clears both. A set event in the same cycle as ERR_CLR wins (flag=1).
- EN=0:
  - FSM returns to IDLE next cycle, counters cleared, partial frame dropped silently.
  - RX_DATA, RX_VALID and flags are retained; handshake continues to operate.
- Latency: with BAUDDIV=4 (64 cycles/bit), RX_VALID rises 3 + 9*64 + 40 = 619 cycles after the start falling edge on the pin (±1 cycle).

Test Plan:
- Nominal frame: BAUDDIV=4, RXD driven LSB-first 10'b1100100110 (start 0, data 0x93, stop 1), 1280 ns per bit, RX_READY=0 -> RX_VALID=1, RX_DATA=0x93, FERR=0, OVERRUN=0; RX_READY pulse -> RX_VALID=0 next cycle.
- Glitch rejection: RXD low for 3 bit-samples (12 cycles) then high -> BUSY pulses, returns to IDLE, RX_VALID stays 0, no flags.
- Framing error: frame 0x5A with stop bit 0 -> FERR=1, RX_VALID=0. ERR_CLR pulse -> FERR=0. Following valid frame 0x3C is received correctly.
- Overrun: two back-to-back frames 0x11 then 0x22, RX_READY=0 -> RX_DATA=0x11, OVERRUN=1. Repeat with RX_READY asserted on the cycle the second byte loads -> RX_DATA=0x22, OVERRUN=0.
- Reset/enable mid-frame: EN=0 during data bit 4 of 0x93 -> BUSY=0, no RX_VALID. Re-enable and send 0xA5 -> 0xA5 received. HRESET during a frame -> all outputs return to reset values.
- Baud scaling: BAUDDIV=1 (16 cycles/bit), frames 0x00 and 0xFF back-to-back with a one-bit idle gap -> both delivered in order with RX_READY=1, no flags.
